// File: rtl/alu_sequencer.sv
// Multicycle execute stage feeding an external ALU: decodes an instruction word, drives the ALU
// operands and opcode, then writes the ALU result and flags back to the register file and psr.
module alu_sequencer #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 4,
    parameter int FLAG_W     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr,
    output logic [WIDTH-1:0]      alu_A,
    output logic [WIDTH-1:0]      alu_B,
    output logic [7:0]            alu_Opcode,
    input  logic [WIDTH-1:0]      alu_C,
    input  logic [FLAG_W-1:0]     alu_Flags,
    output logic [FLAG_W-1:0]     psr,
    output logic                  done,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data
);

    localparam int NREG = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t                  state;
    logic [15:0]             instr_p0;
    logic [WIDTH-1:0]        regs [NREG];
    logic                    wb_en_p1;
    logic                    flag_en_p1;
    logic [REG_ADDR_W-1:0]   rdest_p1;
    logic [WIDTH-1:0]        c_p2;
    logic [FLAG_W-1:0]       flags_p2;

    logic [3:0]              op_hi;
    logic [3:0]              op_ext;
    logic [REG_ADDR_W-1:0]   rdest;
    logic [REG_ADDR_W-1:0]   rsrc;
    logic [WIDTH-1:0]        dec_a;
    logic [WIDTH-1:0]        dec_b;
    logic [7:0]              dec_op;
    logic                    dec_wb;
    logic                    dec_fl;

    function automatic logic [WIDTH-1:0] sext8(input logic signed [7:0] v);
        return {{(WIDTH-8){v[7]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] zext8(input logic [7:0] v);
        return {{(WIDTH-8){1'b0}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] zext4(input logic [3:0] v);
        return {{(WIDTH-4){1'b0}}, v};
    endfunction

    assign op_hi       = instr_p0[15:12];
    assign op_ext      = instr_p0[7:4];
    assign rdest       = instr_p0[8 +: REG_ADDR_W];
    assign rsrc        = instr_p0[0 +: REG_ADDR_W];
    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    // Operands come from the register file as it stands in DECODE, so Rdest==Rsrc sees the old value.
    always_comb begin
        dec_a  = regs[rdest];
        dec_b  = regs[rsrc];
        dec_op = 8'h00;
        dec_wb = 1'b0;
        dec_fl = 1'b0;
        unique case (op_hi)
            4'h0: begin
                dec_op = {4'h0, op_ext};
                if (op_ext != 4'h0) begin
                    dec_fl = 1'b1;
                    dec_wb = !(op_ext == 4'hB || op_ext == 4'hF);
                end
            end
            4'h5, 4'h7, 4'h9: begin
                dec_op = {4'h0, op_hi};
                dec_b  = sext8(instr_p0[7:0]);
                dec_wb = 1'b1;
                dec_fl = 1'b1;
            end
            4'h6: begin
                dec_op = {4'h0, op_hi};
                dec_b  = zext8(instr_p0[7:0]);
                dec_wb = 1'b1;
                dec_fl = 1'b1;
            end
            4'hB: begin
                dec_op = {4'h0, op_hi};
                dec_b  = sext8(instr_p0[7:0]);
                dec_fl = 1'b1;
            end
            4'h8: begin
                dec_op = {4'h8, op_ext};
                if (op_ext <= 4'h1) dec_b = zext4(instr_p0[3:0]);
                dec_wb = 1'b1;
                dec_fl = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            instr_p0   <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_Opcode <= '0;
            wb_en_p1   <= 1'b0;
            flag_en_p1 <= 1'b0;
            rdest_p1   <= '0;
            c_p2       <= '0;
            flags_p2   <= '0;
            psr        <= '0;
            done       <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                // p0: latch the accepted instruction
                IDLE: begin
                    if (instr_valid) begin
                        instr_p0 <= instr;
                        state    <= DECODE;
                    end
                end
                // p1: register ALU drive, held through EXEC and WB
                DECODE: begin
                    alu_A      <= dec_a;
                    alu_B      <= dec_b;
                    alu_Opcode <= dec_op;
                    wb_en_p1   <= dec_wb;
                    flag_en_p1 <= dec_fl;
                    rdest_p1   <= rdest;
                    state      <= EXEC;
                end
                // p2: capture ALU result and flags
                EXEC: begin
                    c_p2     <= alu_C;
                    flags_p2 <= alu_Flags;
                    state    <= WB;
                end
                // p3: retire
                WB: begin
                    if (wb_en_p1) regs[rdest_p1] <= c_p2;
                    if (flag_en_p1) psr <= flags_p2;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: plays the ALU itself and checks every retired instruction against
// an instruction-level model of the register file and psr.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_A;
    logic [15:0] alu_B;
    logic [7:0]  alu_Opcode;
    logic [15:0] alu_C;
    logic [4:0]  alu_Flags;
    logic [4:0]  psr;
    logic        done;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_sequencer #(.WIDTH(16), .REG_ADDR_W(4), .FLAG_W(5)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_A(alu_A), .alu_B(alu_B), .alu_Opcode(alu_Opcode),
        .alu_C(alu_C), .alu_Flags(alu_Flags), .psr(psr), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_reg [16];
    logic [4:0]  m_psr;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] b;
        logic        wb;
        logic        fl;
        logic        known;
    } dec_t;

    // ALU behaviour: {Z,C,F,N,L, result}
    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        cy;
        logic        ov;
        s = 17'h0;
        case (op)
            8'h05, 8'h06, 8'h07: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[15:0];
                cy = s[16];
                ov = (a[15] == b[15]) && (r[15] != a[15]);
            end
            8'h09, 8'h0B, 8'h0F: begin
                s  = {1'b0, a} - {1'b0, b};
                r  = s[15:0];
                cy = s[16];
                ov = (a[15] != b[15]) && (r[15] != a[15]);
            end
            default: begin
                r  = a ^ {b[14:0], b[15]} ^ {8'h00, op};
                cy = ^r;
                ov = r[0];
            end
        endcase
        return {(r == 16'h0), cy, ov, r[15], (a < b), r};
    endfunction

    // The ALU answers correctly only in the EXEC cycle; any other time it shows junk.
    logic        alu_live = 1'b0;
    logic [31:0] junk = 32'h0;
    logic [20:0] alu_out;
    always @(posedge clk) junk <= $urandom;
    assign alu_out   = alu_fn(alu_Opcode, alu_A, alu_B);
    assign alu_C     = alu_live ? alu_out[15:0]  : junk[15:0];
    assign alu_Flags = alu_live ? alu_out[20:16] : junk[20:16];

    function automatic dec_t ref_decode(input logic [15:0] w);
        dec_t        d;
        logic [3:0]  hi;
        logic [3:0]  ext;
        logic [15:0] rs;
        logic [15:0] simm;
        hi   = w[15:12];
        ext  = w[7:4];
        rs   = m_reg[w[3:0]];
        simm = 16'($signed(w[7:0]));
        d    = '0;
        d.known = 1'b1;
        if (hi == 4'h0) begin
            d.op = {4'h0, ext};
            d.b  = rs;
            d.fl = (ext != 4'h0);
            d.wb = d.fl && (ext != 4'hB) && (ext != 4'hF);
        end else if (hi == 4'h5 || hi == 4'h6 || hi == 4'h7 || hi == 4'h9 || hi == 4'hB) begin
            d.op = {4'h0, hi};
            d.b  = (hi == 4'h6) ? {8'h00, w[7:0]} : simm;
            d.wb = (hi != 4'hB);
            d.fl = 1'b1;
        end else if (hi == 4'h8) begin
            d.op = {4'h8, ext};
            d.b  = (ext < 4'h2) ? {12'h000, w[3:0]} : rs;
            d.wb = 1'b1;
            d.fl = 1'b1;
        end else begin
            d.known = 1'b0;
        end
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
        m_psr = 5'h0;
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check(tag, dbg_data, m_reg[i]);
        end
    endtask

    task automatic run(input logic [15:0] w);
        dec_t        d;
        logic [15:0] a;
        logic [20:0] res;
        logic [3:0]  rd;
        rd  = w[11:8];
        d   = ref_decode(w);
        a   = m_reg[rd];
        res = alu_fn(d.op, a, d.b);
        @(negedge clk);
        check("ready_idle", instr_ready, 1);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        check("ready_busy", instr_ready, 0);
        @(posedge clk);
        #1;
        alu_live = 1'b1;
        check("alu_A", alu_A, a);
        if (d.known) begin
            check("alu_B", alu_B, d.b);
            check("alu_Opcode", alu_Opcode, d.op);
        end
        @(posedge clk);
        #1;
        alu_live = 1'b0;
        dbg_addr = rd;
        #1;
        check("dbg_old", dbg_data, m_reg[rd]);
        check("done_early", done, 0);
        if (d.known) check("alu_B_held", alu_B, d.b);
        @(posedge clk);
        #1;
        if (d.wb) m_reg[rd] = res[15:0];
        if (d.fl) m_psr = res[20:16];
        check("done_pulse", done, 1);
        check("dbg_new", dbg_data, m_reg[rd]);
        check("psr", psr, m_psr);
        check("ready_back", instr_ready, 1);
        @(posedge clk);
        #1;
        check("done_single", done, 0);
    endtask

    logic [3:0] hi_tab [8];

    initial begin
        dec_t        d;
        logic [20:0] res;
        hi_tab = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h8, 4'hA};
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        dbg_addr    = 4'h0;
        model_clear();
        #12;
        reset = 1'b0;
        @(negedge clk);
        sweep_regs("reset_reg");
        check("reset_psr", psr, 0);
        check("reset_ready", instr_ready, 1);
        check("reset_done", done, 0);
        check("reset_alu_A", alu_A, 0);
        check("reset_alu_B", alu_B, 0);
        check("reset_alu_Opcode", alu_Opcode, 0);

        run(16'h5105);
        check("addi_r1", m_reg[1], 16'h0005);
        run(16'h52FF);
        check("addi_r2", m_reg[2], 16'hFFFF);
        run(16'h63FF);
        check("addui_r3", m_reg[3], 16'h00FF);
        run(16'h0152);
        check("add_r1", m_reg[1], 16'h0004);
        run(16'h01B1);
        run(16'hA123);
        run(16'h0000);
        run(16'h8312);
        run(16'h8333);
        run(16'h9401);
        run(16'hB480);

        // Reset lands in the EXEC cycle of ADDI R4,#7.
        @(negedge clk);
        instr       = 16'h5407;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        alu_live = 1'b1;
        #2;
        reset = 1'b1;
        #2;
        reset    = 1'b0;
        alu_live = 1'b0;
        model_clear();
        @(negedge clk);
        dbg_addr = 4'h4;
        #1;
        check("abort_r4", dbg_data, 0);
        check("abort_psr", psr, 0);
        check("abort_ready", instr_ready, 1);
        check("abort_done", done, 0);
        sweep_regs("abort_reg");

        // instr_valid stays high through the whole instruction: only one acceptance.
        d   = ref_decode(16'h5501);
        res = alu_fn(d.op, m_reg[5], d.b);
        @(negedge clk);
        instr       = 16'h5501;
        instr_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        alu_live = 1'b1;
        @(posedge clk);
        #1;
        alu_live = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        m_reg[5] = res[15:0];
        m_psr    = res[20:16];
        check("held_done", done, 1);
        repeat (3) @(posedge clk);
        #1;
        dbg_addr = 4'h5;
        #1;
        check("held_r5_once", dbg_data, 16'h0001);
        check("held_ready", instr_ready, 1);
        check("held_done_low", done, 0);
        check("held_psr", psr, m_psr);

        for (int i = 0; i < 16; i++) run({4'h5, 4'(i), 8'($urandom)});
        for (int i = 0; i < 40; i++) run({hi_tab[$urandom_range(0, 7)], 12'($urandom)});
        @(negedge clk);
        sweep_regs("final_reg");
        check("final_psr", psr, m_psr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
